// File: rtl/per_link_arbiter.sv
// per_link_arbiter
//   Round-robin arbiter and four-phase handshake sequencer sharing one
//   peripheral send/ack link among N_REQ requesters. One requester is granted
//   per transaction; its data is presented on per_dados while per_send is
//   raised, and a one-cycle done pulse is returned to it after the peripheral
//   has acked and released.
//
//   Optional feature (macro ARB_TIMEOUT_EN): a watchdog aborts a handshake
//   that stays TIMEOUT_CYC cycles in SEND or RELEASE, pulsing done and err
//   together. Without the macro there is no counter and err is tied to 0.
//
// Ports
//   arb_clk    in   clock, rising edge
//   arb_rst    in   asynchronous active-low reset
//   req        in   [N_REQ]          per-requester request level
//   req_dados  in   [N_REQ*DATA_W]   requester i data at [i*DATA_W +: DATA_W]
//   done       out  [N_REQ]          one-cycle completion pulse to the winner
//   err        out  1                timeout flag, coincident with done
//   busy       out  1                high whenever not IDLE
//   grant_id   out  [clog2(N_REQ)]   current / last granted requester
//   per_send   out  1                handshake request to the peripheral
//   per_dados  out  [DATA_W]         data to the peripheral
//   per_ack    in   1                handshake acknowledge from the peripheral
module per_link_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                      arb_clk,
  input  logic                      arb_rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_dados,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      per_send,
  output logic [DATA_W-1:0]         per_dados,
  input  logic                      per_ack
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StSend, StRelease, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [ID_W-1:0]     r_grant_id, w_grant_id_d;
  logic                r_per_send, w_per_send_d;
  logic [DATA_W-1:0]   r_per_dados, w_per_dados_d;
  logic [N_REQ-1:0]    r_done, w_done_d;
  logic                r_busy, w_busy_d;

  // Round-robin search: first set req bit after the last grant, wrapping.
  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [ID_W-1:0]     w_cand;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_grant_id;
    w_cand   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((32'(r_grant_id) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  logic w_timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd, w_wd_d;
  logic            r_err, w_err_d;

  // Counter value equals cycles already spent in the current state, so the
  // abort edge is the one that would complete TIMEOUT_CYC cycles.
  assign w_timeout = ((r_state == StSend) || (r_state == StRelease)) &&
                     (r_wd == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    if (w_state_d != r_state) begin
      w_wd_d = '0;
    end else if ((r_state == StSend) || (r_state == StRelease)) begin
      w_wd_d = r_wd + 1'b1;
    end else begin
      w_wd_d = r_wd;
    end
  end

  // A real handshake step beats a coincident timeout.
  always_comb begin
    w_err_d = 1'b0;
    if (w_timeout) begin
      w_err_d = (r_state == StSend) ? !per_ack : per_ack;
    end
  end

  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd  <= w_wd_d;
      r_err <= w_err_d;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_d     = r_state;
    w_grant_id_d  = r_grant_id;
    w_per_send_d  = r_per_send;
    w_per_dados_d = r_per_dados;
    w_done_d      = '0;

    unique case (r_state)
      StIdle: begin
        // A stale ack from the previous transaction blocks a new grant.
        if (w_found && !per_ack) begin
          w_state_d     = StSend;
          w_grant_id_d  = w_winner;
          w_per_dados_d = req_dados[w_winner*DATA_W +: DATA_W];
          w_per_send_d  = 1'b1;
        end
      end
      StSend: begin
        if (per_ack) begin
          w_state_d    = StRelease;
          w_per_send_d = 1'b0;
        end else if (w_timeout) begin
          w_state_d              = StDone;
          w_per_send_d           = 1'b0;
          w_done_d[r_grant_id]   = 1'b1;
        end
      end
      StRelease: begin
        if (!per_ack || w_timeout) begin
          w_state_d            = StDone;
          w_done_d[r_grant_id] = 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d    = StIdle;
        w_per_send_d = 1'b0;
      end
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      r_state     <= StIdle;
      r_grant_id  <= ID_W'(N_REQ - 1);
      r_per_send  <= 1'b0;
      r_per_dados <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_grant_id  <= w_grant_id_d;
      r_per_send  <= w_per_send_d;
      r_per_dados <= w_per_dados_d;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
    end
  end

  assign done      = r_done;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;
  assign per_send  = r_per_send;
  assign per_dados = r_per_dados;

endmodule

// File: doc/per_link_arbiter.md
# per_link_arbiter

Round-robin arbiter and handshake sequencer that shares the single peripheral send/ack link among several CPU-side requesters. It grants one requester at a time and drives the peripheral's `per_send` / 4-bit data with a full four-phase handshake. It reports completion to the winning requester. It sits between the requester logic and the peripheral, and is the only driver of the peripheral's inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 4: data width; matches the peripheral data bus.
- `TIMEOUT_CYC`, 15: handshake watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`).

Ports:
- `arb_clk`  in  1: single clock; all logic on its rising edge.
- `arb_rst`  in  1: reset, asynchronous and active-low.
- `req`  in  N_REQ: per-requester request level; held until that requester's `done` pulse.
- `req_dados`  in  N_REQ*DATA_W: requester i's data in bits [i*DATA_W +: DATA_W].
- `done`  out  N_REQ: one-cycle completion pulse to the granted requester.
- `err`  out  1: one-cycle pulse, coincident with `done`, on a timed-out transaction.
- `busy`  out  1: high in every state except IDLE.
- `grant_id`  out  clog2(N_REQ): index of the current or last granted requester.
- `per_send`  out  1: handshake request to the peripheral.
- `per_dados`  out  DATA_W: data to the peripheral; stable while `per_send`=1.
- `per_ack`  in  1: handshake acknowledge from the peripheral.

## Operation
- All outputs are registered.
- Reset values: `done`=0, `err`=0, `busy`=0, `grant_id`=N_REQ-1, `per_send`=0, `per_dados`=0, state IDLE.
- Resetting `grant_id` to N_REQ-1 gives requester 0 first priority after reset.
- States: IDLE, SEND, RELEASE, DONE.
- IDLE → SEND when any `req` bit is 1 and `per_ack`=0.
  - Winner: the first set bit searching upward from `grant_id`+1, wrapping modulo N_REQ.
  - On this transition, latch the winner into `grant_id` and its `req_dados` slice into `per_dados`, and set `per_send`=1.
- In IDLE with `per_ack`=1 (stale ack), no grant is issued.
- SEND → RELEASE when `per_ack`=1 is sampled; `per_send` is cleared on that edge.
- RELEASE → DONE when `per_ack`=0 is sampled; `done[grant_id]` is set on that edge.
- DONE → IDLE unconditionally; `done` is cleared on that edge. DONE lasts exactly one cycle.
- `per_dados` holds its value from grant until the next grant.
- Requester-side events during a transaction:
  - `req` changes after grant are ignored; the transaction always completes.
  - A requester that is still requesting in IDLE after its `done` competes again, with lowest priority.
- Simultaneous requests: exactly one grant per transaction. With all requests continuously asserted, the grant order is 0,1,2,…,N_REQ-1,0,…
- Reset mid-transaction: immediate return to reset values; `per_send` drops asynchronously. No `done` is issued for the aborted transaction.

## Timing
- `req[i]` rises before edge 1 → `per_send`=1 after edge 1.
- Peripheral acks on the next edge. Arbiter samples `per_ack` high at edge 3 → `per_send`=0.
- `per_ack` falls after edge 4 → arbiter samples it low at edge 5 → `done[i]`=1 after edge 5.
- IDLE is reached after edge 6. The next grant can occur at edge 7.
- Nominal throughput: one transaction per 6 cycles against the peripheral's 1-cycle ack response.
- Latency scales 1:1 with extra peripheral ack delay in either phase.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A watchdog counter resets on every state entry and counts cycles spent in SEND or RELEASE.
  - Reaching `TIMEOUT_CYC` forces `per_send`=0 and a transition to DONE, with `done[grant_id]`=1 and `err`=1 for that cycle.
  - The counter width is sufficient for `TIMEOUT_CYC`.
- Not defined:
  - No counter is present; SEND and RELEASE wait indefinitely.
  - `err` is tied to 0.

## Test plan
- Reset, single request: `req`=4'b0100, `req_dados` slice 2 = 4'hA, 1-cycle ack responder.
  - Required: `grant_id`=2, `per_dados`=4'hA, `per_send` high for cycles 1-2.
  - Required: `done`=4'b0100 pulses exactly once, at edge 5; `busy` low after edge 6.
- All four requests held continuously, data 4'h1..4'h4.
  - Required: grants in order 0,1,2,3,0; `per_dados` sequence 1,2,3,4,1; one `done` pulse per grant, 6 cycles apart.
- Ack delayed 3 cycles in each phase.
  - Required: `per_send` and `per_dados` held stable until ack is sampled high; `done` at edge 11; no `err`.
- Stale `per_ack`=1 held in IDLE with `req`=4'b0001.
  - Required: no grant and `per_send`=0 while ack stays high; grant on the first edge that samples ack low.
- Assert `arb_rst`=0 during RELEASE.
  - Required: `per_send`=0 and `busy`=0 immediately; no `done` pulse; after release, requester 0 wins first.
- With `ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=15, `per_ack` stuck 0.
  - Required: `per_send` drops after 15 cycles in SEND; `done` and `err` pulse together; return to IDLE.
  - Without the macro, the same stimulus keeps `per_send`=1 indefinitely.
